// File: rtl/mips_wb_pkg.sv
// Shared widths and the queue entry type for the register write-back path.
package mips_wb_pkg;

  localparam int DATA_W = 32;
  localparam int REG_W  = 5;
  localparam logic [REG_W-1:0] ZERO_REG = 5'd0;

  // One pending register-file write: destination index and value.
  typedef struct packed {
    logic [REG_W-1:0]  rd;
    logic [DATA_W-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/mips_reg_writeback_if.sv
// Result offer bus from the load path and the ALU path into write-back.
//
// Handshake: a producer holds valid and its reg/data stable; the transfer
// happens on the rising edge where valid and ready are both high. Ready is
// never a function of the same path's valid, so there is no combinational
// loop. alu_ready does look at mem_valid, because two accepts per cycle
// share the free space.
interface mips_reg_writeback_if import mips_wb_pkg::*; ();

  logic              mem_valid;
  logic              mem_ready;
  logic [REG_W-1:0]  mem_reg;
  logic [DATA_W-1:0] mem_data;

  logic              alu_valid;
  logic              alu_ready;
  logic [REG_W-1:0]  alu_reg;
  logic [DATA_W-1:0] alu_data;

  modport master (
    output mem_valid, mem_reg, mem_data,
    output alu_valid, alu_reg, alu_data,
    input  mem_ready, alu_ready
  );

  modport slave (
    input  mem_valid, mem_reg, mem_data,
    input  alu_valid, alu_reg, alu_data,
    output mem_ready, alu_ready
  );

endinterface

// File: rtl/mips_wb_fifo.sv
// Two-write / one-read circular buffer of pending register writes.
// Port 0 is written before port 1 when both are enabled, so port 0 is the
// older entry. The age-ordered view (index 0 = oldest) feeds the forwarding
// search; entries at or beyond count_o are marked invalid.
module mips_wb_fifo import mips_wb_pkg::*; #(
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr0_en_i,
  input  wb_entry_t        wr0_entry_i,
  input  logic             wr1_en_i,
  input  wb_entry_t        wr1_entry_i,
  input  logic             rd_en_i,
  output wb_entry_t        head_o,
  output logic [CW-1:0]    count_o,
  output logic             empty_o,
  output logic             full_o,
  output wb_entry_t        age_entry_o [DEPTH],
  output logic [DEPTH-1:0] age_valid_o
);

  wb_entry_t     mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          empty_q, full_q;
  logic [CW-1:0] n_wr;

  // Next pointers and occupancy; pointer arithmetic wraps since DEPTH is a power of two.
  always_comb begin
    n_wr     = CW'(wr0_en_i) + CW'(wr1_en_i);
    wr_ptr_d = wr_ptr_q + AW'(n_wr);
    rd_ptr_d = rd_ptr_q + AW'(rd_en_i);
    count_d  = count_q + n_wr - CW'(rd_en_i);
  end

  // Control state; the storage itself needs no reset because count gates it.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      empty_q  <= 1'b1;
      full_q   <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      empty_q  <= (count_d == '0);
      full_q   <= (count_d == CW'(DEPTH));
    end
  end

  // Storage writes: port 1 lands after port 0 when both are active.
  always_ff @(posedge clk) begin
    if (wr0_en_i) mem_q[wr_ptr_q] <= wr0_entry_i;
    if (wr1_en_i) mem_q[wr0_en_i ? wr_ptr_q + AW'(1) : wr_ptr_q] <= wr1_entry_i;
  end

  // Age-ordered view of the live entries, oldest first.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      age_entry_o[i] = mem_q[rd_ptr_q + AW'(i)];
      age_valid_o[i] = (CW'(i) < count_q);
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;
  assign empty_o = empty_q;
  assign full_o  = full_q;

endmodule

// File: rtl/mips_reg_writeback.sv
// Register-file write-back initiator: accepts load and ALU results, queues
// them in order, retires one per cycle to the register file write port and
// forwards queued or retiring values to decode.
module mips_reg_writeback import mips_wb_pkg::*; #(
  parameter  int DEPTH = 4,
  localparam int CW    = $clog2(DEPTH) + 1
) (
  input  logic                 clk,
  input  logic                 reset,
  mips_reg_writeback_if.slave  wb_in,
  input  logic                 wb_hold,
  output logic [REG_W-1:0]     write_reg,
  output logic [DATA_W-1:0]    write_data,
  output logic                 signal_reg_write,
  input  logic [REG_W-1:0]     query_reg_1,
  input  logic [REG_W-1:0]     query_reg_2,
  output logic                 fwd_hit_1,
  output logic                 fwd_hit_2,
  output logic [DATA_W-1:0]    fwd_data_1,
  output logic [DATA_W-1:0]    fwd_data_2,
  output logic [CW-1:0]        count,
  output logic                 empty,
  output logic                 full
);

  wb_entry_t         head;
  wb_entry_t         age_entry [DEPTH];
  logic [DEPTH-1:0]  age_valid;
  wb_entry_t         mem_entry, alu_entry;
  logic              mem_store, alu_store, pop;

  logic              srw_q;
  logic [REG_W-1:0]  write_reg_q;
  logic [DATA_W-1:0] write_data_q;

  // Space comes from the registered count only; a same-cycle pop gives no credit.
  assign wb_in.mem_ready = !full;
  assign wb_in.alu_ready = (({1'b0, count} + (CW+1)'(wb_in.mem_valid)) < (CW+1)'(DEPTH));

  // Accepted results to register 0 complete the handshake but are dropped here.
  assign mem_store = wb_in.mem_valid && wb_in.mem_ready &&
                     (wb_in.mem_reg != ZERO_REG) && !reset;
  assign alu_store = wb_in.alu_valid && wb_in.alu_ready &&
                     (wb_in.alu_reg != ZERO_REG) && !reset;
  assign pop       = !empty && !wb_hold && !reset;

  assign mem_entry = '{rd: wb_in.mem_reg, data: wb_in.mem_data};
  assign alu_entry = '{rd: wb_in.alu_reg, data: wb_in.alu_data};

  // The load result goes in port 0 so it is older than a same-cycle ALU result.
  mips_wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk         (clk),
    .reset       (reset),
    .wr0_en_i    (mem_store),
    .wr0_entry_i (mem_entry),
    .wr1_en_i    (alu_store),
    .wr1_entry_i (alu_entry),
    .rd_en_i     (pop),
    .head_o      (head),
    .count_o     (count),
    .empty_o     (empty),
    .full_o      (full),
    .age_entry_o (age_entry),
    .age_valid_o (age_valid)
  );

  // Retire register: pulse the write enable for one cycle per popped entry, else hold index/data.
  always_ff @(posedge clk) begin
    if (reset) begin
      srw_q        <= 1'b0;
      write_reg_q  <= '0;
      write_data_q <= '0;
    end else if (pop) begin
      srw_q        <= 1'b1;
      write_reg_q  <= head.rd;
      write_data_q <= head.data;
    end else begin
      srw_q        <= 1'b0;
    end
  end

  assign signal_reg_write = srw_q;
  assign write_reg        = write_reg_q;
  assign write_data       = write_data_q;

  // Forwarding: retiring write is lowest priority, then queue oldest to youngest, so youngest wins.
  always_comb begin
    fwd_hit_1  = 1'b0;
    fwd_data_1 = '0;
    fwd_hit_2  = 1'b0;
    fwd_data_2 = '0;
    if (srw_q && (write_reg_q == query_reg_1)) begin
      fwd_hit_1  = 1'b1;
      fwd_data_1 = write_data_q;
    end
    if (srw_q && (write_reg_q == query_reg_2)) begin
      fwd_hit_2  = 1'b1;
      fwd_data_2 = write_data_q;
    end
    for (int i = 0; i < DEPTH; i++) begin
      if (age_valid[i] && (age_entry[i].rd == query_reg_1)) begin
        fwd_hit_1  = 1'b1;
        fwd_data_1 = age_entry[i].data;
      end
      if (age_valid[i] && (age_entry[i].rd == query_reg_2)) begin
        fwd_hit_2  = 1'b1;
        fwd_data_2 = age_entry[i].data;
      end
    end
    if (query_reg_1 == ZERO_REG) begin
      fwd_hit_1  = 1'b0;
      fwd_data_1 = '0;
    end
    if (query_reg_2 == ZERO_REG) begin
      fwd_hit_2  = 1'b0;
      fwd_data_2 = '0;
    end
  end

endmodule

// File: tb/tb_mips_reg_writeback.sv
// Bench for mips_reg_writeback (DEPTH=4): a cycle-by-cycle vector table for
// the basic flows plus directed sequences for fill/hold/drain and reset.
module tb_mips_reg_writeback;
  import mips_wb_pkg::*;

  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mips_reg_writeback_if bus ();

  logic              wb_hold;
  logic [REG_W-1:0]  write_reg;
  logic [DATA_W-1:0] write_data;
  logic              signal_reg_write;
  logic [REG_W-1:0]  query_reg_1, query_reg_2;
  logic              fwd_hit_1, fwd_hit_2;
  logic [DATA_W-1:0] fwd_data_1, fwd_data_2;
  logic [CW-1:0]     count;
  logic              empty, full;

  mips_reg_writeback #(.DEPTH(DEPTH)) dut (
    .clk              (clk),
    .reset            (reset),
    .wb_in            (bus),
    .wb_hold          (wb_hold),
    .write_reg        (write_reg),
    .write_data       (write_data),
    .signal_reg_write (signal_reg_write),
    .query_reg_1      (query_reg_1),
    .query_reg_2      (query_reg_2),
    .fwd_hit_1        (fwd_hit_1),
    .fwd_hit_2        (fwd_hit_2),
    .fwd_data_1       (fwd_data_1),
    .fwd_data_2       (fwd_data_2),
    .count            (count),
    .empty            (empty),
    .full             (full)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [REG_W+DATA_W-1:0] exp_q [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic mv, input logic [REG_W-1:0] mr, input logic [DATA_W-1:0] md,
                       input logic av, input logic [REG_W-1:0] ar, input logic [DATA_W-1:0] ad,
                       input logic hold);
    bus.mem_valid = mv;
    bus.mem_reg   = mr;
    bus.mem_data  = md;
    bus.alu_valid = av;
    bus.alu_reg   = ar;
    bus.alu_data  = ad;
    wb_hold       = hold;
  endtask

  task automatic idle();
    drive(1'b0, '0, '0, 1'b0, '0, '0, 1'b0);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic              mv;
    logic [REG_W-1:0]  mreg;
    logic [DATA_W-1:0] mdata;
    logic              av;
    logic [REG_W-1:0]  areg;
    logic [DATA_W-1:0] adata;
    logic              hold;
    logic [REG_W-1:0]  q1;
    logic [REG_W-1:0]  q2;
    logic              e_mr;
    logic              e_ar;
    logic              e_h1;
    logic [DATA_W-1:0] e_d1;
    logic              e_h2;
    logic [DATA_W-1:0] e_d2;
    logic              e_srw;
    logic [REG_W-1:0]  e_wreg;
    logic [DATA_W-1:0] e_wdata;
    logic [CW-1:0]     e_cnt;
  } vec_t;

  localparam int NVEC = 14;
  vec_t vecs [NVEC];

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    // Inputs: mv mreg mdata | av areg adata | hold q1 q2
    // Pre-edge:  mem_ready alu_ready hit1 data1 hit2 data2
    // Post-edge: srw write_reg write_data count
    vecs[0]  = '{1, 8, 32'hDEADBEEF, 0, 0, 0,        0, 8, 0, 1, 1, 0, 0,            0, 0,      0, 8'd0, 0,            1};
    vecs[1]  = '{0, 0, 0,            0, 0, 0,        0, 8, 0, 1, 1, 1, 32'hDEADBEEF, 0, 0,      1, 8,    32'hDEADBEEF, 0};
    vecs[2]  = '{1, 3, 32'h11,       1, 4, 32'h22,   0, 8, 3, 1, 1, 1, 32'hDEADBEEF, 0, 0,      0, 8,    32'hDEADBEEF, 2};
    vecs[3]  = '{0, 0, 0,            0, 0, 0,        0, 3, 4, 1, 1, 1, 32'h11,       1, 32'h22, 1, 3,    32'h11,       1};
    vecs[4]  = '{0, 0, 0,            0, 0, 0,        0, 3, 4, 1, 1, 1, 32'h11,       1, 32'h22, 1, 4,    32'h22,       0};
    vecs[5]  = '{0, 0, 0,            1, 0, 32'hFFFF, 0, 0, 4, 1, 1, 0, 0,            1, 32'h22, 0, 4,    32'h22,       0};
    vecs[6]  = '{0, 0, 0,            0, 0, 0,        0, 0, 4, 1, 1, 0, 0,            0, 0,      0, 4,    32'h22,       0};
    vecs[7]  = '{1, 9, 32'hA,        0, 0, 0,        1, 9, 9, 1, 1, 0, 0,            0, 0,      0, 4,    32'h22,       1};
    vecs[8]  = '{0, 0, 0,            1, 9, 32'hB,    1, 9, 9, 1, 1, 1, 32'hA,        1, 32'hA,  0, 4,    32'h22,       2};
    vecs[9]  = '{0, 0, 0,            0, 0, 0,        1, 9, 9, 1, 1, 1, 32'hB,        1, 32'hB,  0, 4,    32'h22,       2};
    vecs[10] = '{0, 0, 0,            0, 0, 0,        0, 9, 9, 1, 1, 1, 32'hB,        1, 32'hB,  1, 9,    32'hA,        1};
    vecs[11] = '{0, 0, 0,            0, 0, 0,        0, 9, 9, 1, 1, 1, 32'hB,        1, 32'hB,  1, 9,    32'hB,        0};
    vecs[12] = '{0, 0, 0,            0, 0, 0,        0, 9, 9, 1, 1, 1, 32'hB,        1, 32'hB,  0, 9,    32'hB,        0};
    vecs[13] = '{0, 0, 0,            0, 0, 0,        0, 9, 9, 1, 1, 0, 0,            0, 0,      0, 9,    32'hB,        0};

    // ---------------- reset ----------------
    reset       = 1'b1;
    query_reg_1 = '0;
    query_reg_2 = '0;
    idle();
    tick();
    tick();
    chk("rst_count", 32'(count), 0);
    chk("rst_empty", 32'(empty), 1);
    chk("rst_full", 32'(full), 0);
    chk("rst_srw", 32'(signal_reg_write), 0);
    chk("rst_wreg", 32'(write_reg), 0);
    chk("rst_wdata", write_data, 0);
    chk("rst_mem_ready", 32'(bus.mem_ready), 1);
    chk("rst_alu_ready", 32'(bus.alu_ready), 1);
    reset = 1'b0;

    // ---------------- table-driven flows ----------------
    for (int v = 0; v < NVEC; v++) begin
      drive(vecs[v].mv, vecs[v].mreg, vecs[v].mdata, vecs[v].av, vecs[v].areg, vecs[v].adata, vecs[v].hold);
      query_reg_1 = vecs[v].q1;
      query_reg_2 = vecs[v].q2;
      #1;
      chk($sformatf("v%0d_mem_ready", v), 32'(bus.mem_ready), 32'(vecs[v].e_mr));
      chk($sformatf("v%0d_alu_ready", v), 32'(bus.alu_ready), 32'(vecs[v].e_ar));
      chk($sformatf("v%0d_fwd_hit_1", v), 32'(fwd_hit_1), 32'(vecs[v].e_h1));
      chk($sformatf("v%0d_fwd_data_1", v), fwd_data_1, vecs[v].e_d1);
      chk($sformatf("v%0d_fwd_hit_2", v), 32'(fwd_hit_2), 32'(vecs[v].e_h2));
      chk($sformatf("v%0d_fwd_data_2", v), fwd_data_2, vecs[v].e_d2);
      tick();
      chk($sformatf("v%0d_srw", v), 32'(signal_reg_write), 32'(vecs[v].e_srw));
      chk($sformatf("v%0d_wreg", v), 32'(write_reg), 32'(vecs[v].e_wreg));
      chk($sformatf("v%0d_wdata", v), write_data, vecs[v].e_wdata);
      chk($sformatf("v%0d_count", v), 32'(count), 32'(vecs[v].e_cnt));
      chk($sformatf("v%0d_empty", v), 32'(empty), 32'(vecs[v].e_cnt == 0));
    end
    idle();
    query_reg_1 = '0;
    query_reg_2 = '0;

    // ---------------- fill under hold, then drain in order ----------------
    for (int i = 0; i < DEPTH; i++) begin
      drive(1'b0, '0, '0, 1'b1, REG_W'(10 + i), DATA_W'(100 + i), 1'b1);
      #1;
      chk($sformatf("fill%0d_alu_ready", i), 32'(bus.alu_ready), 1);
      exp_q.push_back({REG_W'(10 + i), DATA_W'(100 + i)});
      tick();
      chk($sformatf("fill%0d_srw", i), 32'(signal_reg_write), 0);
      chk($sformatf("fill%0d_count", i), 32'(count), 32'(i + 1));
    end
    // Full and held: both paths offered, neither accepted.
    drive(1'b1, 5'd21, 32'h2121, 1'b1, 5'd20, 32'h2020, 1'b1);
    #1;
    chk("full_mem_ready", 32'(bus.mem_ready), 0);
    chk("full_alu_ready", 32'(bus.alu_ready), 0);
    chk("full_flag", 32'(full), 1);
    tick();
    chk("full_hold_srw", 32'(signal_reg_write), 0);
    chk("full_hold_count", 32'(count), 4);
    // Full with a pop this cycle: still no acceptance.
    wb_hold = 1'b0;
    #1;
    chk("full_pop_mem_ready", 32'(bus.mem_ready), 0);
    chk("full_pop_alu_ready", 32'(bus.alu_ready), 0);
    tick();
    idle();
    for (int c = 0; c < 8; c++) begin
      if (signal_reg_write) begin
        if (exp_q.size() == 0) begin
          chk("drain_unexpected_pulse", 32'(signal_reg_write), 0);
        end else begin
          logic [REG_W+DATA_W-1:0] e;
          e = exp_q.pop_front();
          chk("drain_wreg", 32'(write_reg), 32'(e[REG_W+DATA_W-1:DATA_W]));
          chk("drain_wdata", write_data, e[DATA_W-1:0]);
        end
      end
      tick();
    end
    chk("drain_remaining", 32'(exp_q.size()), 0);
    chk("drain_count", 32'(count), 0);
    chk("drain_srw", 32'(signal_reg_write), 0);

    // ---------------- reset with three entries queued ----------------
    drive(1'b1, 5'd5, 32'h55, 1'b1, 5'd6, 32'h66, 1'b1);
    tick();
    chk("pre_rst_count2", 32'(count), 2);
    drive(1'b1, 5'd7, 32'h77, 1'b0, '0, '0, 1'b1);
    #1;
    chk("cnt2_alu_ready", 32'(bus.alu_ready), 1);
    tick();
    chk("pre_rst_count3", 32'(count), 3);
    drive(1'b1, 5'd12, 32'hC, 1'b1, 5'd13, 32'hD, 1'b0);
    reset = 1'b1;
    #1;
    chk("cnt3_mem_ready", 32'(bus.mem_ready), 1);
    chk("cnt3_alu_ready", 32'(bus.alu_ready), 0);
    tick();
    reset = 1'b0;
    idle();
    chk("mid_rst_count", 32'(count), 0);
    chk("mid_rst_empty", 32'(empty), 1);
    chk("mid_rst_full", 32'(full), 0);
    chk("mid_rst_srw", 32'(signal_reg_write), 0);
    chk("mid_rst_wreg", 32'(write_reg), 0);
    chk("mid_rst_wdata", write_data, 0);
    for (int c = 0; c < 6; c++) begin
      tick();
      chk($sformatf("post_rst%0d_srw", c), 32'(signal_reg_write), 0);
      chk($sformatf("post_rst%0d_count", c), 32'(count), 0);
    end

    // ---------------- report ----------------
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mips_reg_writeback.md
# mips_reg_writeback

Write-back initiator for the MIPS register file write port. Collects register results from the memory (load) path and the ALU path through valid/ready handshakes and buffers them in a small in-order queue. Retires one result per cycle onto `write_reg` / `write_data` / `signal_reg_write`, which connect directly to the register file. Also provides a forwarding lookup, so decode can see values that are queued but not yet written.

## Interface
- `DEPTH`, 4: queue entries; power of two, ≥ 2.
- `DATA_W`, 32: result width.
- `REG_W`, 5: register index width.

- `clk` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `mem_valid` in 1: load result offered.
- `mem_ready` out 1: load result accepted when valid & ready.
- `mem_reg` in REG_W: destination register of load.
- `mem_data` in DATA_W: load value.
- `alu_valid` in 1: ALU result offered.
- `alu_ready` out 1: ALU result accepted when valid & ready.
- `alu_reg` in REG_W: destination register of ALU result.
- `alu_data` in DATA_W: ALU value.
- `wb_hold` in 1: block retirement this cycle; queue keeps accepting.
- `write_reg` out REG_W: register file write index.
- `write_data` out DATA_W: register file write value.
- `signal_reg_write` out 1: register file write enable; one-cycle pulse per retired entry.
- `query_reg_1`, `query_reg_2` in REG_W: forwarding lookup indices.
- `fwd_hit_1`, `fwd_hit_2` out 1: query matches a pending or retiring write.
- `fwd_data_1`, `fwd_data_2` out DATA_W: matching value; 0 when no hit.
- `count` out $clog2(DEPTH)+1: entries held.
- `empty`, `full` out 1: count==0 / count==DEPTH.

## Operation
- **Enqueue.** Up to two entries per cycle.
  - `mem_ready` = !full.
  - `alu_ready` = (count + mem_valid) < DEPTH. It depends on `mem_valid`, never on `alu_valid`.
  - Space is computed from the current count only; a same-cycle retirement gives no credit.
- **Order.** When both paths are accepted in one cycle, the mem entry is enqueued first (older instruction), then the alu entry.
- **Register 0.** An accepted result whose destination is register 0 completes the handshake but is not stored. It does not count, retire, or hit.
- **Retire.** If !empty and !wb_hold, the head is popped. On the next edge, `write_reg`/`write_data` load the head and `signal_reg_write`=1. Otherwise `signal_reg_write`=0 and `write_reg`/`write_data` hold their previous values.
- **Count update.** count_next = count + stored_enqueues − pop. Pointers wrap modulo DEPTH.
- **Forwarding (combinational).**
  - Search order: queue entries youngest to oldest, then the output register when `signal_reg_write`=1.
  - The first match wins, so the youngest write to the same register supplies the data.
  - A query of 0 never hits.
- **Reset.** count=0, pointers=0, `signal_reg_write`=0, `write_reg`=0, `write_data`=0, `empty`=1, `full`=0. After reset `mem_ready`=1, and `alu_ready`=1 when `DEPTH`≥2.
- **Reset mid-operation.** Queued entries are discarded without being written. Any handshake in the reset cycle is ignored.

## Timing
- Latency into an empty queue: accept at edge N → `signal_reg_write`=1 in cycle N+1 (write visible after edge N+1).
- Throughput: one retirement per cycle; up to two accepts per cycle.
- Two results accepted at edge N into an empty queue → mem retires in N+1, alu in N+2.
- `wb_hold` high in cycle N → no pulse in N+1.
- Full with a pop in the same cycle: `mem_ready`=0 for that cycle (no pass-through).
- Forwarding reflects state as of the current cycle's registers; same-cycle incoming results are not forwarded.
- `fwd_hit`/`fwd_data` and both ready outputs are combinational. All other outputs are registered.

## Structure
- Package `mips_wb_pkg`:
  - constants DATA_W=32, REG_W=5, ZERO_REG=5'd0;
  - typedef `wb_entry_t` {reg index, data}.
- Sub-module `mips_wb_fifo`: 2-write/1-read circular buffer with storage, pointers, count, full/empty, plus a per-entry view for the forwarding search.
- Top level: ready logic, register-0 filter, retire register, two forwarding comparators.

## Test plan
- Reset, then mem_valid with mem_reg=8 and mem_data=32'hDEADBEEF → mem_ready=1; next cycle signal_reg_write=1, write_reg=8, write_data=32'hDEADBEEF; the cycle after, signal_reg_write=0.
- Same cycle: mem(reg 3, 32'h11) and alu(reg 4, 32'h22) → pulses in the next two cycles, reg 3 first, then reg 4; count goes 2→1→0.
- wb_hold=1 with alu results offered every cycle, DEPTH=4 → full after 4 accepts; alu_ready=0 and mem_ready=0; no signal_reg_write pulses. Drop hold → 4 pulses in FIFO order, then idle.
- alu result to reg 0 (32'hFFFF) → handshake completes, count stays 0, no pulse; query_reg_1=0 → fwd_hit_1=0.
- Hold set, enqueue reg 9=32'hA then reg 9=32'hB; query_reg_2=9 → fwd_hit_2=1, fwd_data_2=32'hB. Release hold and drain → after the final pulse, fwd_hit_2=0.
- Queue holding 3 entries, assert reset → next cycle count=0, empty=1, signal_reg_write=0, and no write of the discarded entries in any later cycle.
